// File: rtl/mult_bcd_seq_pkg.sv
// rtl/mult_bcd_seq_pkg.sv - shared types and sizing helpers for the BCD shift-add multiplier
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      CONV = 2'd2,
      DONE = 2'd3
   } state_t;

   function automatic int default_digits(input int n);
      return (2 * n) / 3 + 1;
   endfunction

   // Step counter must hold 2N
   function automatic int cnt_width(input int n);
      return $clog2(2 * n + 1);
   endfunction

endpackage

// File: rtl/mult_bcd_seq_if.sv
// rtl/mult_bcd_seq_if.sv - request/result bundle between a requester and the multiplier
interface mult_bcd_seq_if
   import mult_pkg::*;
#(
   parameter int N      = 8,
   parameter int DIGITS = default_digits(N)
);
   logic                  start;
   logic                  is_signed;
   logic [N-1:0]          a_in;
   logic [N-1:0]          b_in;
   logic                  busy;
   logic                  done;
   logic [2*N-1:0]        out;
   logic                  neg;
   logic [4*DIGITS-1:0]   bcd;

   modport master (
      output start, is_signed, a_in, b_in,
      input  busy, done, out, neg, bcd
   );

   modport slave (
      input  start, is_signed, a_in, b_in,
      output busy, done, out, neg, bcd
   );
endinterface

// File: rtl/mult_bcd_seq_bin2bcd.sv
// rtl/mult_bcd_seq_bin2bcd.sv - serial double-dabble converter, one binary bit per shift_en
module bin2bcd_serial #(
   parameter int W      = 16,
   parameter int DIGITS = 6
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                i_load,
   input  logic                i_shift_en,
   input  logic                i_serial,
   output logic [4*DIGITS-1:0] o_bcd,
   output logic                o_conv_done
);
   localparam int BW = 4 * DIGITS;
   localparam int SW = $clog2(W + 1);

   logic [BW-1:0] r_bcd;
   logic [BW-1:0] w_adj;
   logic [SW-1:0] r_shifts;

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      assign w_adj[4*g +: 4] = (r_bcd[4*g +: 4] >= 4'd5) ? r_bcd[4*g +: 4] + 4'd3
                                                         : r_bcd[4*g +: 4];
   end

   // Top digit carry-out is dropped: DIGITS is sized so it is always zero
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_bcd    <= '0;
         r_shifts <= '0;
      end else if (i_load) begin
         r_bcd    <= '0;
         r_shifts <= '0;
      end else if (i_shift_en) begin
         r_bcd    <= BW'({w_adj, i_serial});
         r_shifts <= r_shifts + SW'(1);
      end
   end

   assign o_bcd       = r_bcd;
   assign o_conv_done = (r_shifts == SW'(W));

endmodule

// File: rtl/mult_bcd_seq.sv
// rtl/mult_bcd_seq.sv - sequential signed/unsigned shift-add multiplier with BCD readout
module mult_bcd_seq
   import mult_pkg::*;
#(
   parameter int N      = 8,
   parameter int DIGITS = default_digits(N)
) (
   input  logic          clock,
   input  logic          reset,
   mult_bcd_seq_if.slave bus
);
   localparam int CW = cnt_width(N);
   localparam int W2 = 2 * N;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [W2-1:0]       r_ma;
   logic [N:0]          r_mb;
   logic [W2-1:0]       r_acc;
   logic [W2-1:0]       r_conv;
   logic [CW-1:0]       r_cnt;
   logic                r_sgn;
   logic [W2-1:0]       r_out;
   logic                r_neg;
   logic [4*DIGITS-1:0] r_bcd;

   logic [N:0]          w_a_ext;
   logic [N:0]          w_b_ext;
   logic [N:0]          w_a_mag;
   logic [N:0]          w_b_mag;
   logic [W2-1:0]       w_acc_step;
   logic                w_load;
   logic                w_shift_en;
   logic                w_conv_done;
   logic [4*DIGITS-1:0] w_bcd;

   // One extra bit so that -2^(N-1) has a representable magnitude
   assign w_a_ext    = {bus.is_signed & bus.a_in[N-1], bus.a_in};
   assign w_b_ext    = {bus.is_signed & bus.b_in[N-1], bus.b_in};
   assign w_a_mag    = w_a_ext[N] ? -w_a_ext : w_a_ext;
   assign w_b_mag    = w_b_ext[N] ? -w_b_ext : w_b_ext;
   assign w_acc_step = r_mb[0] ? r_acc + r_ma : r_acc;

   assign w_load     = (r_state == IDLE) && bus.start;
   assign w_shift_en = (r_state == CONV) && !w_conv_done;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (bus.start) w_state_nxt = MUL;
         MUL:     if (r_cnt == CW'(1)) w_state_nxt = CONV;
         CONV:    if (w_conv_done) w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_ma   <= '0;
         r_mb   <= '0;
         r_acc  <= '0;
         r_conv <= '0;
         r_cnt  <= '0;
         r_sgn  <= 1'b0;
         r_out  <= '0;
         r_neg  <= 1'b0;
         r_bcd  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_ma  <= W2'(w_a_mag);
                  r_mb  <= w_b_mag;
                  r_sgn <= bus.is_signed & (bus.a_in[N-1] ^ bus.b_in[N-1]);
                  r_acc <= '0;
                  r_cnt <= CW'(N);
               end
            end
            MUL: begin
               r_acc <= w_acc_step;
               r_ma  <= r_ma << 1;
               r_mb  <= r_mb >> 1;
               r_cnt <= r_cnt - CW'(1);
               // Snapshot the final product for the converter; r_acc stays intact for out
               if (r_cnt == CW'(1)) r_conv <= w_acc_step;
            end
            CONV: begin
               if (w_shift_en) r_conv <= r_conv << 1;
               if (w_conv_done) begin
                  r_out <= r_sgn ? -r_acc : r_acc;
                  r_neg <= r_sgn & (r_acc != '0);
                  r_bcd <= w_bcd;
               end
            end
            default: ;
         endcase
      end
   end

   bin2bcd_serial #(
      .W      (W2),
      .DIGITS (DIGITS)
   ) u_bin2bcd (
      .clock       (clock),
      .reset       (reset),
      .i_load      (w_load),
      .i_shift_en  (w_shift_en),
      .i_serial    (r_conv[W2-1]),
      .o_bcd       (w_bcd),
      .o_conv_done (w_conv_done)
   );

   assign bus.busy = (r_state != IDLE);
   assign bus.done = (r_state == DONE);
   assign bus.out  = r_out;
   assign bus.neg  = r_neg;
   assign bus.bcd  = r_bcd;

endmodule

// File: tb/tb_mult_bcd_seq.sv
// tb/tb_mult_bcd_seq.sv - directed self-checking bench for mult_bcd_seq (N=8)
module tb_mult_bcd_seq;

   typedef struct {
      logic [15:0] o;
      logic        n;
      logic [23:0] d;
   } exp_t;

   localparam int LAT = 25;

   logic clk;
   logic rst_n;
   int   cyc;
   int   checks;
   int   failures;
   int   n_done;
   int   acc_cyc;
   bit   in_flight;
   bit   checking;
   exp_t q[$];
   exp_t held;
   logic exp_busy;
   logic exp_done;

   mult_bcd_seq_if #(.N(8)) bus ();

   mult_bcd_seq #(.N(8)) dut (
      .clock (clk),
      .reset (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Product from plain integer arithmetic, digits by repeated division
   function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic s);
      exp_t   e;
      longint av, bv, p, m;
      av  = s ? longint'($signed(a)) : longint'(a);
      bv  = s ? longint'($signed(b)) : longint'(b);
      p   = av * bv;
      e.o = p[15:0];
      e.n = (p < 0);
      m   = (p < 0) ? -p : p;
      e.d = '0;
      for (int i = 0; i < 6; i++) begin
         e.d[4*i +: 4] = 4'(m % 10);
         m = m / 10;
      end
      return e;
   endfunction

   always @(negedge clk) begin
      if (rst_n && checking) begin
         exp_busy = in_flight && (cyc <= acc_cyc + LAT);
         exp_done = in_flight && (cyc == acc_cyc + LAT);
         if (exp_done) begin
            chk("result_queue_empty", 32'(q.size() == 0), 32'd0);
            if (q.size() != 0) held = q.pop_front();
         end
         chk("busy", 32'(bus.busy), 32'(exp_busy));
         chk("done", 32'(bus.done), 32'(exp_done));
         chk("out",  32'(bus.out),  32'(held.o));
         chk("neg",  32'(bus.neg),  32'(held.n));
         chk("bcd",  32'(bus.bcd),  32'(held.d));
         if (bus.done) n_done++;
         if (in_flight && cyc >= acc_cyc + LAT + 1) in_flight = 1'b0;
      end
   end

   task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic s);
      @(negedge clk);
      bus.start     = 1'b1;
      bus.is_signed = s;
      bus.a_in      = a;
      bus.b_in      = b;
      @(posedge clk);
      #1;
      acc_cyc   = cyc;
      in_flight = 1'b1;
      q.push_back(model(a, b, s));
      @(negedge clk);
      bus.start     = 1'b0;
      bus.a_in      = ~a;
      bus.b_in      = b + 8'd1;
      bus.is_signed = ~s;
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while (in_flight && k < 100) begin
         @(negedge clk);
         #1;
         k++;
      end
      chk("idle_timeout", 32'(in_flight), 32'd0);
      if (in_flight) begin
         in_flight = 1'b0;
         q.delete();
      end
   endtask

   task automatic run(input logic [7:0] a, input logic [7:0] b, input logic s,
                      input logic [15:0] o, input logic n, input logic [23:0] d);
      exp_t m;
      m = model(a, b, s);
      chk("model_out", 32'(m.o), 32'(o));
      chk("model_neg", 32'(m.n), 32'(n));
      chk("model_bcd", 32'(m.d), 32'(d));
      issue(a, b, s);
      wait_idle();
      chk("lit_out", 32'(bus.out), 32'(o));
      chk("lit_neg", 32'(bus.neg), 32'(n));
      chk("lit_bcd", 32'(bus.bcd), 32'(d));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nd0;
      checks        = 0;
      failures      = 0;
      n_done        = 0;
      cyc           = 0;
      acc_cyc       = 0;
      in_flight     = 1'b0;
      checking      = 1'b0;
      held          = '{o: 16'd0, n: 1'b0, d: 24'd0};
      rst_n         = 1'b0;
      bus.start     = 1'b0;
      bus.is_signed = 1'b0;
      bus.a_in      = 8'd0;
      bus.b_in      = 8'd0;

      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_out",  32'(bus.out),  32'd0);
      chk("rst_neg",  32'(bus.neg),  32'd0);
      chk("rst_bcd",  32'(bus.bcd),  32'd0);
      #2 rst_n = 1'b1;
      checking = 1'b1;

      run(8'd200, 8'd250, 1'b0, 16'd50000, 1'b0, 24'h050000);
      run(8'hF9,  8'd6,   1'b1, 16'hFFD6,  1'b1, 24'h000042);
      run(8'h80,  8'h80,  1'b1, 16'd16384, 1'b0, 24'h016384);
      run(8'h80,  8'h01,  1'b1, 16'hFF80,  1'b1, 24'h000128);
      run(8'h00,  8'hFB,  1'b1, 16'h0000,  1'b0, 24'h000000);
      run(8'hFF,  8'hFF,  1'b0, 16'hFE01,  1'b0, 24'h065025);
      run(8'hFF,  8'hFF,  1'b1, 16'h0001,  1'b0, 24'h000001);
      run(8'h7F,  8'h80,  1'b1, 16'hC080,  1'b1, 24'h016256);

      // Second start while multiplying must be dropped
      nd0 = n_done;
      issue(8'd3, 8'd5, 1'b0);
      while (cyc < acc_cyc + 3) @(negedge clk);
      bus.start = 1'b1;
      bus.a_in  = 8'd9;
      bus.b_in  = 8'd9;
      repeat (2) @(negedge clk);
      bus.start = 1'b0;
      wait_idle();
      chk("midstart_out", 32'(bus.out), 32'd15);
      chk("midstart_bcd", 32'(bus.bcd), 32'h000015);
      chk("midstart_done_count", 32'(n_done - nd0), 32'd1);

      // Reset in the middle of conversion
      issue(8'd99, 8'd99, 1'b0);
      while (cyc < acc_cyc + 12) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("conv_rst_busy", 32'(bus.busy), 32'd0);
      chk("conv_rst_done", 32'(bus.done), 32'd0);
      chk("conv_rst_out",  32'(bus.out),  32'd0);
      chk("conv_rst_neg",  32'(bus.neg),  32'd0);
      chk("conv_rst_bcd",  32'(bus.bcd),  32'd0);
      in_flight = 1'b0;
      q.delete();
      held = '{o: 16'd0, n: 1'b0, d: 24'd0};
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      run(8'd13, 8'd11, 1'b0, 16'd143, 1'b0, 24'h000143);

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mult_bcd_seq.md
# mult_bcd_seq

Parametrised sequential shift-add multiplier with a built-in serial binary-to-BCD converter, signed/unsigned mode and a start/busy/done handshake. It replaces the fixed-width unsigned multiplier in the arithmetic datapath. It feeds the display/readout logic that consumes packed BCD digits plus a sign flag. Operands are captured on start, so the source is free to change them while the block is busy.

## Interface
- N, default 8: operand width in bits, N ≥ 2.
- DIGITS, default (2N)/3+1: number of BCD digits in the bcd output. This is sufficient for the maximum product magnitude.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request. Sampled only in IDLE.
- is_signed  in  1  operand mode, latched with start. 1 = two's complement, 0 = unsigned.
- a_in  in  N  multiplicand, latched with start.
- b_in  in  N  multiplier, latched with start.
- busy  out  1  high in MUL, CONV and DONE.
- done  out  1  one-cycle pulse while in DONE.
- out  out  2N  product: two's complement in signed mode, plain binary otherwise.
- neg  out  1  product is negative. Always 0 in unsigned mode and when the product is zero.
- bcd  out  4*DIGITS  packed BCD of |product|, least-significant digit in [3:0].

## Operation
- FSM states: IDLE → MUL → CONV → DONE → IDLE.
- IDLE:
  - If start=1, latch mode and operands.
  - In signed mode, replace each operand by its magnitude. N-bit -2^(N-1) becomes magnitude 2^(N-1) in an (N+1)-bit internal register.
  - Record sgn = a[N-1]^b[N-1], qualified by is_signed.
  - Clear the accumulator, load the step counter with N, go to MUL.
- MUL: one multiplier bit per cycle.
  - If mb[0]=1, acc += ma.
  - Then ma <<= 1, mb >>= 1, counter -= 1.
  - When the counter reaches 0, go to CONV.
- CONV: serial double-dabble over the 2N-bit |acc|, MSB first, one bit per cycle, 2N cycles.
  - Each cycle, every digit ≥5 gets +3, then the whole BCD register shifts left by one with the next acc bit shifted in.
  - The digit loop is generated from DIGITS; there are no hard-coded digit slices.
- DONE: register the results.
  - out = sgn ? -acc : acc, truncated to 2N bits.
  - neg = sgn & (acc≠0).
  - bcd = converted value.
  - done=1 for this single cycle, then go to IDLE.
- out, neg and bcd change only on the DONE-entry edge and hold until the next DONE.
- start is ignored in MUL, CONV and DONE. It is never queued.
- Async reset (reset=0), at any time including mid-operation:
  - State goes to IDLE.
  - busy, done, out, neg and bcd are forced to 0.
  - All internal registers are cleared.
  - Operation resumes on the first rising clock edge after reset is released.

## Timing
- Start is accepted at edge E0.
- The N multiply steps occur at edges E1..EN.
- The 2N conversion steps occur at edges EN+1..E3N.
- Results and done=1 are visible after edge E3N+1. Total latency from accept to done is 3N+1 cycles.
- IDLE is re-entered at E3N+2. The next start can be accepted at E3N+2, giving a throughput of one product per 3N+2 cycles.
- busy rises after E0 and falls after E3N+2.
- Widths:
  - acc is 2N bits and never overflows, since |product| ≤ 2^(2N-2) signed and (2^N-1)^2 unsigned.
  - The step counter is $clog2(2N+1) bits.

## Structure
- Package mult_pkg holds:
  - the state enum (IDLE, MUL, CONV, DONE);
  - a function default_digits(n) = (2n)/3+1;
  - a localparam helper for counter width.
- Sub-module bin2bcd_serial (parameters W, DIGITS) holds the shift register and per-digit add-3 logic.
  - It is driven by load/shift_en and a serial bit from the parent.
  - The parent keeps the FSM, the multiply datapath and the output registers.

## Test plan
- Unsigned, N=8: 200×250.
  - out=16'd50000, neg=0, bcd=24'h050000.
  - done pulses exactly 25 cycles after accept.
- Signed, N=8: -7×6.
  - out=16'hFFD6, neg=1, bcd=24'h000042.
- Signed corner, N=8: -128×-128.
  - out=16'd16384, neg=0, bcd=24'h016384.
  - Also -128×1: out=16'hFF80, neg=1, bcd=24'h000128.
- Signed zero, N=8: 0×-5.
  - out=0, neg=0, bcd=0.
- Start pulsed again mid-MUL with different operands.
  - Ignored: the first result is unchanged, and a single done pulse is seen.
- reset asserted during CONV.
  - All outputs are 0 immediately, without a clock edge.
  - After release, a new 13×11 request gives out=143, bcd=24'h000143.
